// File: rtl/dac_spi_tx.sv
// Serial transmitter that frames DAC samples as {PFX, data} and shifts them
// MSB first over an SPI-style link (sclk idles low, data valid on sclk rise),
// followed by an active-low LDAC pulse. One word may wait in a pending buffer
// while a frame is in flight; a second waiting word replaces it and sets ovf.
module dac_spi_tx #(
  parameter int               W_AIO = 16,
  parameter int               W_PFX = 8,
  parameter logic [W_PFX-1:0] PFX   = 8'h10,
  parameter int               DIV   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             smp,
  input  logic [W_AIO-1:0] dat,
  input  logic             ovf_clr,
  output logic             sclk,
  output logic             sdo,
  output logic             cs_n,
  output logic             ldac_n,
  output logic             busy,
  output logic             ovf
);

  localparam int FW    = W_PFX + W_AIO;
  localparam int DIV_W = $clog2(DIV + 1);
  localparam int BIT_W = $clog2(FW + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    TRAIL = 3'd3,
    LOAD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic [DIV_W-1:0]   div_cnt_r, div_cnt_s;
  logic [BIT_W-1:0]   bit_cnt_r, bit_cnt_s;
  logic               half_r, half_s;
  logic [FW-1:0]      shreg_r, shreg_s;
  logic               pend_vld_r, pend_vld_s;
  logic [W_AIO-1:0]   pend_dat_r, pend_dat_s;
  logic               smp_prev_r;
  logic               ovf_r, ovf_s, ovf_set_s;
  logic               sclk_r, sclk_s;
  logic               cs_n_r, cs_n_s;
  logic               ldac_n_r, ldac_n_s;
  logic               busy_r, busy_s;

  logic               edge_s;
  logic               phase_end_s;
  logic               last_gap_s;
  logic [FW-1:0]      frame_new_s;
  logic [FW-1:0]      frame_pend_s;

  assign edge_s       = smp & ~smp_prev_r;
  assign phase_end_s  = (div_cnt_r == DIV_W'(DIV - 1));
  assign last_gap_s   = (state_r == GAP) && phase_end_s;
  assign frame_new_s  = {PFX, dat};
  assign frame_pend_s = {PFX, pend_dat_r};

  // Frame sequencer: phase timing, bit counting and shift register updates.
  always_comb begin
    state_s   = state_r;
    div_cnt_s = div_cnt_r;
    bit_cnt_s = bit_cnt_r;
    half_s    = half_r;
    shreg_s   = shreg_r;
    if (state_r == IDLE) begin
      div_cnt_s = '0;
    end else if (phase_end_s) begin
      div_cnt_s = '0;
    end else begin
      div_cnt_s = div_cnt_r + DIV_W'(1);
    end
    case (state_r)
      IDLE: begin
        if (edge_s) begin
          state_s = LEAD;
          shreg_s = frame_new_s;
        end else begin
          state_s = IDLE;
        end
      end
      LEAD: begin
        if (phase_end_s) begin
          state_s   = SHIFT;
          bit_cnt_s = '0;
          half_s    = 1'b0;
        end else begin
          state_s = LEAD;
        end
      end
      SHIFT: begin
        if (phase_end_s) begin
          if (!half_r) begin
            half_s = 1'b1;
          end else if (bit_cnt_r == BIT_W'(FW - 1)) begin
            half_s  = 1'b0;
            state_s = TRAIL;
          end else begin
            // next bit starts: the only point where sdo may change
            half_s    = 1'b0;
            bit_cnt_s = bit_cnt_r + BIT_W'(1);
            shreg_s   = {shreg_r[FW-2:0], 1'b0};
          end
        end else begin
          state_s = SHIFT;
        end
      end
      TRAIL: begin
        if (phase_end_s) state_s = LOAD;
        else             state_s = TRAIL;
      end
      LOAD: begin
        if (phase_end_s) state_s = GAP;
        else             state_s = LOAD;
      end
      GAP: begin
        if (phase_end_s) begin
          // a sample arriving right now is newer than anything pending
          if (edge_s) begin
            state_s = LEAD;
            shreg_s = frame_new_s;
          end else if (pend_vld_r) begin
            state_s = LEAD;
            shreg_s = frame_pend_s;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        state_s   = IDLE;
        div_cnt_s = '0;
        bit_cnt_s = '0;
        half_s    = 1'b0;
      end
    endcase
  end

  // Pending buffer and sticky overrun flag (a set beats a simultaneous clear).
  always_comb begin
    pend_vld_s = pend_vld_r;
    pend_dat_s = pend_dat_r;
    ovf_set_s  = 1'b0;
    if (edge_s && (state_r != IDLE)) begin
      ovf_set_s = pend_vld_r;
      if (last_gap_s) begin
        pend_vld_s = 1'b0;
      end else begin
        pend_vld_s = 1'b1;
        pend_dat_s = dat;
      end
    end else if (last_gap_s) begin
      pend_vld_s = 1'b0;
    end else begin
      pend_vld_s = pend_vld_r;
    end
    if (ovf_set_s)    ovf_s = 1'b1;
    else if (ovf_clr) ovf_s = 1'b0;
    else              ovf_s = ovf_r;
  end

  // Pin values derived from the next state so registered outputs line up with it.
  always_comb begin
    sclk_s   = (state_s == SHIFT) && half_s;
    cs_n_s   = !((state_s == LEAD) || (state_s == SHIFT) || (state_s == TRAIL));
    ldac_n_s = (state_s != LOAD);
    busy_s   = (state_s != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      div_cnt_r  <= '0;
      bit_cnt_r  <= '0;
      half_r     <= 1'b0;
      shreg_r    <= '0;
      pend_vld_r <= 1'b0;
      pend_dat_r <= '0;
      smp_prev_r <= 1'b1;
      ovf_r      <= 1'b0;
      sclk_r     <= 1'b0;
      cs_n_r     <= 1'b1;
      ldac_n_r   <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      div_cnt_r  <= div_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      half_r     <= half_s;
      shreg_r    <= shreg_s;
      pend_vld_r <= pend_vld_s;
      pend_dat_r <= pend_dat_s;
      smp_prev_r <= smp;
      ovf_r      <= ovf_s;
      sclk_r     <= sclk_s;
      cs_n_r     <= cs_n_s;
      ldac_n_r   <= ldac_n_s;
      busy_r     <= busy_s;
    end
  end

  assign sclk   = sclk_r;
  assign sdo    = shreg_r[FW-1];
  assign cs_n   = cs_n_r;
  assign ldac_n = ldac_n_r;
  assign busy   = busy_r;
  assign ovf    = ovf_r;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboard bench for dac_spi_tx: expected frame words are queued as samples
// are driven; monitors rebuild words from sdo on each sclk rise.
module tb_dac_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, smp = 1'b0, ovf_clr = 1'b0;
  logic [15:0] dat = 16'h0000;
  logic        sclk, sdo, cs_n, ldac_n, busy, ovf;
  logic        smp_b = 1'b0, ovf_clr_b = 1'b0;
  logic [19:0] dat_b = 20'h00000;
  logic        sclk_b, sdo_b, cs_n_b, ldac_n_b, busy_b, ovf_b;

  int n_cmp = 0, n_err = 0;

  logic [23:0] exp_q[$], got_q[$], got_b_q[$];
  int nb_q[$], cs_q[$], ld_q[$], bz_q[$], st_q[$];
  bit sync_q[$];
  int nb_b_q[$], cs_b_q[$], bz_b_q[$];
  int per_min_b = 1000, per_max_b = 0;

  dac_spi_tx u_dut (
    .clk(clk), .rst_n(rst_n), .smp(smp), .dat(dat), .ovf_clr(ovf_clr),
    .sclk(sclk), .sdo(sdo), .cs_n(cs_n), .ldac_n(ldac_n), .busy(busy), .ovf(ovf)
  );

  dac_spi_tx #(.W_AIO(20), .W_PFX(4), .PFX(4'hA), .DIV(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .smp(smp_b), .dat(dat_b), .ovf_clr(ovf_clr_b),
    .sclk(sclk_b), .sdo(sdo_b), .cs_n(cs_n_b), .ldac_n(ldac_n_b), .busy(busy_b), .ovf(ovf_b)
  );

  // Monitor for the default instance, sampling on the falling edge.
  initial begin : mon_a
    int cyc, nb, cl, ll, bl;
    logic ps, pc, pl, pb;
    logic [23:0] w;
    cyc = 0; nb = 0; cl = 0; ll = 0; bl = 0;
    ps = 1'b0; pc = 1'b1; pl = 1'b1; pb = 1'b0; w = 24'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!cs_n && pc) begin w = 24'h0; nb = 0; cl = 0; st_q.push_back(cyc); end
      if (!cs_n) cl++;
      if (sclk && !ps && !cs_n) begin w = {w[22:0], sdo}; nb++; end
      if (cs_n && !pc) begin
        got_q.push_back(w); nb_q.push_back(nb); cs_q.push_back(cl); sync_q.push_back(!ldac_n);
      end
      if (!ldac_n) begin if (pl) ll = 0; ll++; end
      if (ldac_n && !pl) ld_q.push_back(ll);
      if (busy) begin if (!pb) bl = 0; bl++; end
      if (!busy && pb) bz_q.push_back(bl);
      ps = sclk; pc = cs_n; pl = ldac_n; pb = busy;
    end
  end

  // Monitor for the DIV=1 instance, also tracking the sclk period.
  initial begin : mon_b
    int cyc, nb, cl, bl, lr;
    logic ps, pc, pb;
    logic [23:0] w;
    cyc = 0; nb = 0; cl = 0; bl = 0; lr = 0;
    ps = 1'b0; pc = 1'b1; pb = 1'b0; w = 24'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!cs_n_b && pc) begin w = 24'h0; nb = 0; cl = 0; end
      if (!cs_n_b) cl++;
      if (sclk_b && !ps && !cs_n_b) begin
        if (nb > 0) begin
          if (cyc - lr < per_min_b) per_min_b = cyc - lr;
          if (cyc - lr > per_max_b) per_max_b = cyc - lr;
        end
        lr = cyc; w = {w[22:0], sdo_b}; nb++;
      end
      if (cs_n_b && !pc) begin got_b_q.push_back(w); nb_b_q.push_back(nb); cs_b_q.push_back(cl); end
      if (busy_b) begin if (!pb) bl = 0; bl++; end
      if (!busy_b && pb) bz_b_q.push_back(bl);
      ps = sclk_b; pc = cs_n_b; pb = busy_b;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Two-cycle smp pulse; the word is queued as expected only if it should be sent.
  task automatic send(input logic [15:0] d, input bit keep);
    if (keep) exp_q.push_back({8'h10, d});
    smp = 1'b1; dat = d;
    tick(2);
    smp = 1'b0;
  endtask

  task automatic clr_q;
    exp_q.delete(); got_q.delete(); nb_q.delete(); cs_q.delete();
    ld_q.delete(); bz_q.delete(); st_q.delete(); sync_q.delete();
  endtask

  task automatic wait_done(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (got_q.size() >= n && !busy) begin ok = 1'b1; break; end
      tick(1);
    end
    tick(3);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(3);
    n_cmp++;
    if ({sclk, sdo, cs_n, ldac_n, busy, ovf} !== 6'b001100) begin
      n_err++; $display("FAIL reset_a: got %b want 001100", {sclk, sdo, cs_n, ldac_n, busy, ovf});
    end
    n_cmp++;
    if ({sclk_b, sdo_b, cs_n_b, ldac_n_b, busy_b, ovf_b} !== 6'b001100) begin
      n_err++; $display("FAIL reset_b: got %b want 001100", {sclk_b, sdo_b, cs_n_b, ldac_n_b, busy_b, ovf_b});
    end
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_single;
    bit ok;
    clr_q();
    send(16'hA55A, 1'b1);
    wait_done(1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL single_timeout: got busy=%b want frame done", busy); end
    n_cmp++; if (got_q.size() !== 1) begin n_err++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    n_cmp++; if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL single_word: got %h want %h", got_q[0], exp_q[0]); end
    n_cmp++; if (nb_q[0] !== 24) begin n_err++; $display("FAIL single_bits: got %0d want 24", nb_q[0]); end
    n_cmp++; if (cs_q[0] !== 100) begin n_err++; $display("FAIL single_cs_len: got %0d want 100", cs_q[0]); end
    n_cmp++; if (ld_q[0] !== 2) begin n_err++; $display("FAIL single_ldac_len: got %0d want 2", ld_q[0]); end
    n_cmp++; if (sync_q[0] !== 1'b1) begin n_err++; $display("FAIL single_ldac_at_cs_rise: got %b want 1", sync_q[0]); end
    n_cmp++; if (bz_q[0] !== 104) begin n_err++; $display("FAIL single_busy_len: got %0d want 104", bz_q[0]); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL single_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    clr_q();
    send(16'h1234, 1'b1);
    tick(48);
    send(16'h0001, 1'b1);
    wait_done(2, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_timeout: got busy=%b want frames done", busy); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (st_q[1] - st_q[0] !== 104) begin n_err++; $display("FAIL b2b_start_gap: got %0d want 104", st_q[1] - st_q[0]); end
    n_cmp++; if (bz_q[0] !== 208) begin n_err++; $display("FAIL b2b_busy_len: got %0d want 208", bz_q[0]); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_overrun;
    bit ok;
    clr_q();
    send(16'h1111, 1'b1);
    tick(18);
    send(16'h2222, 1'b0);
    tick(18);
    send(16'h3333, 1'b1);
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", ovf); end
    wait_done(2, ok);
    n_cmp++; if (!ok || got_q.size() !== 2) begin n_err++; $display("FAIL ovr_count: got %0d want 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovr_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", ovf); end
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", ovf); end
    // clear in the same cycle as a fresh overrun
    clr_q();
    send(16'h4444, 1'b1);
    tick(18);
    send(16'h5555, 1'b0);
    tick(18);
    exp_q.push_back({8'h10, 16'h6666});
    smp = 1'b1; dat = 16'h6666; ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    tick(1);
    smp = 1'b0;
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovr_set_beats_clr: got %b want 1", ovf); end
    wait_done(2, ok);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovr2_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
  endtask

  task automatic test_gap_edge;
    bit ok;
    clr_q();
    send(16'h7777, 1'b1);
    tick(102);
    send(16'h8888, 1'b1);
    wait_done(2, ok);
    n_cmp++; if (!ok || got_q.size() !== 2) begin n_err++; $display("FAIL gap_count: got %0d want 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL gap_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (st_q[1] - st_q[0] !== 104) begin n_err++; $display("FAIL gap_start_gap: got %0d want 104", st_q[1] - st_q[0]); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL gap_ovf: got %b want 0", ovf); end
    // same edge, but with a word already pending: pending word is dropped
    clr_q();
    send(16'h9999, 1'b1);
    tick(48);
    send(16'hAAAA, 1'b0);
    tick(52);
    send(16'hBBBB, 1'b1);
    wait_done(2, ok);
    n_cmp++; if (!ok || got_q.size() !== 2) begin n_err++; $display("FAIL gap2_count: got %0d want 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL gap2_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (st_q[1] - st_q[0] !== 104) begin n_err++; $display("FAIL gap2_start_gap: got %0d want 104", st_q[1] - st_q[0]); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL gap2_ovf: got %b want 1", ovf); end
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    clr_q();
    send(16'hC000, 1'b0);
    tick(8);
    send(16'hC001, 1'b0);
    tick(8);
    send(16'hC002, 1'b0);
    tick(8);
    n_cmp++;
    if ({cs_n, ovf} !== 2'b01) begin n_err++; $display("FAIL rst_pre: got cs_n/ovf %b want 01", {cs_n, ovf}); end
    rst_n = 1'b0; smp = 1'b1;
    #1;
    n_cmp++;
    if ({sclk, sdo, cs_n, ldac_n, busy, ovf} !== 6'b001100) begin
      n_err++; $display("FAIL rst_mid: got %b want 001100", {sclk, sdo, cs_n, ldac_n, busy, ovf});
    end
    tick(3);
    clr_q();
    rst_n = 1'b1;
    tick(150);
    n_cmp++; if (st_q.size() !== 0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_smp_high: got starts=%0d busy=%b want 0 0", st_q.size(), busy); end
    smp = 1'b0;
    tick(3);
    send(16'hD00D, 1'b1);
    wait_done(1, ok);
    n_cmp++; if (!ok || got_q.size() !== 1) begin n_err++; $display("FAIL rst_pend_cleared: got %0d frames want 1", got_q.size()); end
    n_cmp++; if (got_q[0] !== exp_q[0]) begin n_err++; $display("FAIL rst_word: got %h want %h", got_q[0], exp_q[0]); end
  endtask

  task automatic test_div1;
    bit ok;
    ok = 1'b0;
    smp_b = 1'b1; dat_b = 20'hFFFFF;
    tick(2);
    smp_b = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (got_b_q.size() >= 1 && !busy_b) begin ok = 1'b1; break; end
      tick(1);
    end
    tick(3);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL div1_timeout: got busy=%b want frame done", busy_b); end
    n_cmp++; if (got_b_q[0] !== 24'hAFFFFF) begin n_err++; $display("FAIL div1_word: got %h want afffff", got_b_q[0]); end
    n_cmp++; if (nb_b_q[0] !== 24) begin n_err++; $display("FAIL div1_bits: got %0d want 24", nb_b_q[0]); end
    n_cmp++; if (cs_b_q[0] !== 50) begin n_err++; $display("FAIL div1_cs_len: got %0d want 50", cs_b_q[0]); end
    n_cmp++; if (bz_b_q[0] !== 52) begin n_err++; $display("FAIL div1_busy_len: got %0d want 52", bz_b_q[0]); end
    n_cmp++;
    if (per_min_b !== 2 || per_max_b !== 2) begin
      n_err++; $display("FAIL div1_sclk_period: got %0d..%0d want 2", per_min_b, per_max_b);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_gap_edge();
    test_reset_mid();
    test_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
